servo_sort_sequencer: RTL and testbench

Sequences the turntable and track servo drivers for one sort operation per accepted instruction. It replaces ad-hoc enable/position sequencing with a handshake-driven FSM, synchronized and debounced limit switches, per-phase timeouts, and a latched fault. It sits between the serial instruction receiver (upstream) and the two 50 MHz / 30 ms servo drivers (downstream). It guarantees that the two servo enables are never high together.

---
 rtl/servo_sort_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_servo_sort_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sort_sequencer.sv
// Sort-operation sequencer: drives the turntable servo, then the track servo, from one
// accepted instruction, with conditioned limit switches, per-phase timeouts and a latched fault.
module servo_sort_sequencer #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         SETTLE_CYCLES   = 1500000,
  parameter int         TIMEOUT_CYCLES  = 100000000,
  parameter logic [7:0] TURN_SPEED      = 8'hFF,
  parameter logic [7:0] TRACK_FWD       = 8'hFF,
  parameter logic [7:0] TRACK_BACK      = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        correct,
  input  logic        extended,
  input  logic        retracted,
  input  logic        fault_clear,
  output logic        turntable_enable,
  output logic [7:0]  turntable_position,
  output logic        track_enable,
  output logic [7:0]  track_position,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GP_W = (SETTLE_CYCLES > 1)   ? $clog2(SETTLE_CYCLES)   : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GP_W-1:0] GP_LAST = GP_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [GP_W-1:0] GP_ONE  = GP_W'(1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPIN  = 3'd1,
    S_GAP   = 3'd2,
    S_PUSH  = 3'd3,
    S_PULL  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_corr_sync;
  logic [1:0]      r_ext_sync;
  logic [1:0]      r_ret_sync;
  logic            r_ext_db;
  logic            r_ret_db;
  logic [DB_W-1:0] r_ext_cnt;
  logic [DB_W-1:0] r_ret_cnt;
  logic [GP_W-1:0] r_gap_cnt;
  logic [TO_W-1:0] r_tmo_cnt;
  logic            r_maint;
  logic            w_accept;
  logic            w_done;
  logic            w_fault_take;
  logic [1:0]      w_fault_code;
  logic            w_tmo_hit;
  logic            w_conflict;
  logic            w_timed_state;
  logic            w_unused_instr_bits;

  logic            r_tt_en;
  logic [7:0]      r_tt_pos;
  logic            r_tr_en;
  logic [7:0]      r_tr_pos;
  logic            r_busy;
  logic            r_ready;
  logic            r_done;
  logic            r_fault;
  logic [1:0]      r_fault_code;

  assign w_unused_instr_bits = instr[10] ^ instr[8];
  assign w_tmo_hit     = (r_tmo_cnt == TO_LAST);
  assign w_conflict    = r_ext_db && r_ret_db;
  assign w_timed_state = (r_state == S_SPIN) || (r_state == S_PUSH) || (r_state == S_PULL);

  // Two-flop synchronizers for the asynchronous inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_corr_sync <= 2'b00;
      r_ext_sync  <= 2'b00;
      r_ret_sync  <= 2'b00;
    end else begin
      r_corr_sync <= {r_corr_sync[0], correct};
      r_ext_sync  <= {r_ext_sync[0], extended};
      r_ret_sync  <= {r_ret_sync[0], retracted};
    end
  end

  // Extended switch debouncer: flips only after a full run of disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_db  <= 1'b0;
      r_ext_cnt <= '0;
    end else if (r_ext_sync[1] == r_ext_db) begin
      r_ext_cnt <= '0;
    end else if (r_ext_cnt == DB_LAST) begin
      r_ext_db  <= r_ext_sync[1];
      r_ext_cnt <= '0;
    end else begin
      r_ext_cnt <= r_ext_cnt + DB_ONE;
    end
  end

  // Retracted switch debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret_db  <= 1'b0;
      r_ret_cnt <= '0;
    end else if (r_ret_sync[1] == r_ret_db) begin
      r_ret_cnt <= '0;
    end else if (r_ret_cnt == DB_LAST) begin
      r_ret_db  <= r_ret_sync[1];
      r_ret_cnt <= '0;
    end else begin
      r_ret_cnt <= r_ret_cnt + DB_ONE;
    end
  end

  // Phase counters restart on every state change and saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt <= '0;
      r_tmo_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_gap_cnt <= '0;
      r_tmo_cnt <= '0;
    end else begin
      if ((r_state == S_GAP) && (r_gap_cnt != GP_LAST)) begin
        r_gap_cnt <= r_gap_cnt + GP_ONE;
      end else begin
        r_gap_cnt <= r_gap_cnt;
      end
      if (w_timed_state && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + TO_ONE;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; exits beat timeouts, switch conflict beats everything in PUSH/PULL.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_fault_take = 1'b0;
    w_fault_code = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_SPIN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SPIN: begin
        if (r_corr_sync[1]) begin
          if (r_maint) begin
            w_state_next = S_IDLE;
            w_done       = 1'b1;
          end else begin
            w_state_next = S_GAP;
          end
        end else if (w_tmo_hit) begin
          w_state_next = S_FAULT;
          w_fault_take = 1'b1;
          w_fault_code = 2'd1;
        end else begin
          w_state_next = S_SPIN;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GP_LAST) begin
          w_state_next = S_PUSH;
        end else begin
          w_state_next = S_GAP;
        end
      end
      S_PUSH: begin
        if (w_conflict) begin
          w_state_next = S_FAULT;
          w_fault_take = 1'b1;
          w_fault_code = 2'd0;
        end else if (r_ext_db) begin
          w_state_next = S_PULL;
        end else if (w_tmo_hit) begin
          w_state_next = S_FAULT;
          w_fault_take = 1'b1;
          w_fault_code = 2'd2;
        end else begin
          w_state_next = S_PUSH;
        end
      end
      S_PULL: begin
        if (w_conflict) begin
          w_state_next = S_FAULT;
          w_fault_take = 1'b1;
          w_fault_code = 2'd0;
        end else if (r_ret_db) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_next = S_FAULT;
          w_fault_take = 1'b1;
          w_fault_code = 2'd3;
        end else begin
          w_state_next = S_PULL;
        end
      end
      S_FAULT: begin
        if (fault_clear) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_FAULT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output registers decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tt_en      <= 1'b0;
      r_tt_pos     <= 8'h00;
      r_tr_en      <= 1'b0;
      r_tr_pos     <= TRACK_BACK;
      r_busy       <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
      r_maint      <= 1'b0;
    end else begin
      r_tt_en <= (w_state_next == S_SPIN);
      r_tr_en <= (w_state_next == S_PUSH) || (w_state_next == S_PULL);
      r_busy  <= (w_state_next != S_IDLE);
      r_ready <= (w_state_next == S_IDLE);
      r_done  <= w_done;
      r_fault <= (w_state_next == S_FAULT);
      if (w_accept) begin
        r_maint  <= instr[9];
        r_tt_pos <= instr[9] ? instr[7:0] : TURN_SPEED;
      end else begin
        r_maint  <= r_maint;
        r_tt_pos <= r_tt_pos;
      end
      if (w_state_next == S_PUSH) begin
        r_tr_pos <= TRACK_FWD;
      end else if (w_state_next == S_PULL) begin
        r_tr_pos <= TRACK_BACK;
      end else begin
        r_tr_pos <= r_tr_pos;
      end
      if (w_fault_take) begin
        r_fault_code <= w_fault_code;
      end else begin
        r_fault_code <= r_fault_code;
      end
    end
  end

  assign instr_ready        = r_ready;
  assign turntable_enable   = r_tt_en;
  assign turntable_position = r_tt_pos;
  assign track_enable       = r_tr_en;
  assign track_position     = r_tr_pos;
  assign busy               = r_busy;
  assign done               = r_done;
  assign fault              = r_fault;
  assign fault_code         = r_fault_code;

endmodule

// File: tb/tb_servo_sort_sequencer.sv
// Self-checking bench for servo_sort_sequencer: instruction table with a completion
// scoreboard, plus directed debounce, timeout, conflict and reset sequences.
module tb_servo_sort_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        correct;
  logic        extended;
  logic        retracted;
  logic        fault_clear;
  logic        turntable_enable;
  logic [7:0]  turntable_position;
  logic        track_enable;
  logic [7:0]  track_position;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;

  always #5 clk = ~clk;

  servo_sort_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .correct           (correct),
    .extended          (extended),
    .retracted         (retracted),
    .fault_clear       (fault_clear),
    .turntable_enable  (turntable_enable),
    .turntable_position(turntable_position),
    .track_enable      (track_enable),
    .track_position    (track_position),
    .busy              (busy),
    .done              (done),
    .fault             (fault),
    .fault_code        (fault_code)
  );

  typedef struct {
    logic [10:0] ins;
    logic [7:0]  tpos;
    logic        maint;
  } vec_t;

  typedef struct {
    logic [7:0] tpos;
    logic       track;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic track_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every sampled cycle also checks that the two enables are never high together.
  task automatic tick;
    @(negedge clk);
    if (track_enable) track_seen = 1'b1;
    check("enable_exclusive", 32'(turntable_enable & track_enable), 32'd0);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       sig = track_enable;
      1:       sig = done;
      2:       sig = fault;
      3:       sig = (track_position == 8'h00);
      4:       sig = ~turntable_enable;
      5:       sig = instr_ready;
      default: sig = 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int bound, output int k);
    k = 0;
    while (sig(sel) !== 1'b1 && k < bound) begin
      tick;
      k++;
    end
    check({name, "_reached"}, 32'(sig(sel)), 32'd1);
  endtask

  task automatic start_op(input logic [10:0] ins, input logic [7:0] tpos, input logic maint,
                          input logic expect_done);
    int k;
    exp_t e;
    wait_sig("ready", 5, 20, k);
    instr       = ins;
    instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    track_seen  = 1'b0;
    check("accept_tt_en", 32'(turntable_enable), 32'd1);
    check("accept_tt_pos", 32'(turntable_position), 32'(tpos));
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_not_ready", 32'(instr_ready), 32'd0);
    if (expect_done) begin
      e.tpos  = tpos;
      e.track = ~maint;
      sb_q.push_back(e);
    end
  endtask

  task automatic finish_op;
    int   k;
    exp_t e;
    wait_sig("done", 1, 40, k);
    check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("done_tt_pos", 32'(turntable_position), 32'(e.tpos));
      check("done_track_used", 32'(track_seen), 32'(e.track));
    end
    check("done_idle_ready", 32'(instr_ready), 32'd1);
    tick;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic drive_to_push;
    int k;
    int gap;
    repeat (8) tick;
    correct = 1'b1;
    wait_sig("spin_exit", 4, 10, k);
    correct = 1'b0;
    check("gap_tr_en_low", 32'(track_enable), 32'd0);
    gap = 1;
    while (1) begin
      tick;
      if (track_enable || gap >= 30) break;
      gap++;
    end
    check("gap_length", 32'(gap), 32'd8);
    check("push_tr_en", 32'(track_enable), 32'd1);
    check("push_tr_pos", 32'(track_position), 32'hFF);
  endtask

  task automatic finish_pull;
    repeat (10) tick;
    retracted = 1'b1;
    finish_op;
    retracted = 1'b0;
    repeat (10) tick;
  endtask

  task automatic clear_fault;
    extended  = 1'b0;
    retracted = 1'b0;
    repeat (10) tick;
    fault_clear = 1'b1;
    tick;
    fault_clear = 1'b0;
    check("clear_fault_low", 32'(fault), 32'd0);
    check("clear_ready", 32'(instr_ready), 32'd1);
    check("clear_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_maint(input logic [10:0] ins, input logic [7:0] tpos);
    start_op(ins, tpos, 1'b1, 1'b1);
    repeat (3) tick;
    correct = 1'b1;
    finish_op;
    correct = 1'b0;
    repeat (4) tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int bad;
    vecs[0] = '{11'h000, 8'hFF, 1'b0};
    vecs[1] = '{11'h23C, 8'h3C, 1'b1};
    vecs[2] = '{11'h5A5, 8'hFF, 1'b0};
    vecs[3] = '{11'h7C3, 8'hC3, 1'b1};
    vecs[4] = '{11'h200, 8'h00, 1'b1};

    reset = 1'b1; instr = 11'h000; instr_valid = 1'b0; correct = 1'b0;
    extended = 1'b0; retracted = 1'b0; fault_clear = 1'b0;
    repeat (3) tick;
    check("rst_tt_en", 32'(turntable_enable), 32'd0);
    check("rst_tr_en", 32'(track_enable), 32'd0);
    check("rst_tt_pos", 32'(turntable_position), 32'h00);
    check("rst_tr_pos", 32'(track_position), 32'h00);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    reset = 1'b0;
    tick;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].maint) begin
        run_maint(vecs[i].ins, vecs[i].tpos);
      end else begin
        start_op(vecs[i].ins, vecs[i].tpos, 1'b0, 1'b1);
        drive_to_push;
        repeat (3) tick;
        extended = 1'b1;
        wait_sig("pull", 3, 20, k);
        check("pull_tr_en", 32'(track_enable), 32'd1);
        check("pull_tt_pos", 32'(turntable_position), 32'(vecs[i].tpos));
        extended = 1'b0;
        finish_pull;
      end
    end

    // Debounce: a chattering switch must not move the sequencer.
    start_op(11'h000, 8'hFF, 1'b0, 1'b1);
    drive_to_push;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      extended = 1'b1;
      tick; if (track_position != 8'hFF) bad++;
      tick; if (track_position != 8'hFF) bad++;
      extended = 1'b0;
      tick; if (track_position != 8'hFF) bad++;
      tick; if (track_position != 8'hFF) bad++;
    end
    check("chatter_no_pull", 32'(bad), 32'd0);
    check("chatter_still_push", 32'(track_enable), 32'd1);
    extended = 1'b1;
    k = 0;
    while (track_position != 8'h00 && k < 20) begin
      tick;
      k++;
    end
    check("debounce_latency", 32'(k), 32'd7);
    extended = 1'b0;
    finish_pull;

    // SPIN timeout, instructions ignored in FAULT, then clear and accept again.
    start_op(11'h000, 8'hFF, 1'b0, 1'b0);
    wait_sig("spin_fault", 2, 100, k);
    check("spin_timeout_cycles", 32'(k), 32'd64);
    check("spin_fault_code", 32'(fault_code), 32'd1);
    check("fault_not_ready", 32'(instr_ready), 32'd0);
    check("fault_tt_en", 32'(turntable_enable), 32'd0);
    instr = 11'h23C;
    instr_valid = 1'b1;
    repeat (3) tick;
    instr_valid = 1'b0;
    check("fault_ignores_instr", 32'(fault), 32'd1);
    check("fault_keeps_tt_pos", 32'(turntable_position), 32'hFF);
    clear_fault;
    run_maint(11'h23C, 8'h3C);

    // PUSH timeout.
    start_op(11'h000, 8'hFF, 1'b0, 1'b0);
    drive_to_push;
    wait_sig("push_fault", 2, 100, k);
    check("push_timeout_cycles", 32'(k), 32'd64);
    check("push_fault_code", 32'(fault_code), 32'd2);
    check("push_fault_tr_en", 32'(track_enable), 32'd0);
    check("push_fault_tr_pos", 32'(track_position), 32'hFF);
    clear_fault;

    // Both limit switches active during PUSH.
    start_op(11'h000, 8'hFF, 1'b0, 1'b0);
    drive_to_push;
    extended  = 1'b1;
    retracted = 1'b1;
    wait_sig("conflict_fault", 2, 20, k);
    check("conflict_code", 32'(fault_code), 32'd0);
    check("conflict_tr_en", 32'(track_enable), 32'd0);
    clear_fault;

    // Asynchronous reset in the middle of PUSH.
    start_op(11'h000, 8'hFF, 1'b0, 1'b0);
    drive_to_push;
    tick;
    #2 reset = 1'b1;
    #1;
    check("async_tr_en", 32'(track_enable), 32'd0);
    check("async_tt_en", 32'(turntable_enable), 32'd0);
    check("async_tt_pos", 32'(turntable_position), 32'h00);
    check("async_tr_pos", 32'(track_position), 32'h00);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    check("async_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick;
    run_maint(11'h2A5, 8'hA5);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
